// File: rtl/seq_scan_ctrl_if.sv
// rtl/seq_scan_ctrl_if.sv - word-in / count-out handshake and pattern config bundle for seq_scan_ctrl
interface seq_scan_ctrl_if #(
  parameter int WIDTH    = 16,
  parameter int PLEN_MAX = 8,
  parameter int CW       = $clog2(WIDTH + 1)
);
  logic                cfg_we;
  logic [PLEN_MAX-1:0] cfg_pattern;
  logic [3:0]          cfg_len;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data;
  logic                out_valid;
  logic                out_ready;
  logic [CW-1:0]       out_count;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - serialises a word MSB first through a programmable pattern matcher and reports the match count
module seq_scan_ctrl #(
  parameter int WIDTH    = 16,
  parameter int PLEN_MAX = 8,
  parameter int CW       = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  seq_scan_ctrl_if.slave bus,
  output logic           serial_a,
  output logic           match_y,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [PLEN_MAX-1:0] pat_q;
  logic [3:0]          len_q;
  logic [WIDTH-1:0]    shreg;
  logic [PLEN_MAX-1:0] hist;
  logic [CW-1:0]       bitcnt;
  logic [CW-1:0]       count;

  logic                accept;
  logic                last_bit;
  logic                reached;
  logic                hit;
  logic [3:0]          len_clamp;
  logic [PLEN_MAX-1:0] hist_nxt;
  logic [PLEN_MAX-1:0] len_mask;

  assign accept        = (state == IDLE) && bus.in_valid;
  assign last_bit      = (bitcnt == CW'(WIDTH - 1));
  assign len_clamp     = (bus.cfg_len > 4'(PLEN_MAX)) ? 4'(PLEN_MAX) : bus.cfg_len;
  assign hist_nxt      = {hist[PLEN_MAX-2:0], serial_a};
  assign reached       = (({1'b0, bitcnt} + (CW+1)'(1)) >= (CW+1)'(len_q));
  assign bus.out_count = count;

  // Low len_q bits of history and pattern take part in the compare; a match needs len_q bits already seen.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PLEN_MAX; i++) begin
      len_mask[i] = (len_q > 4'(i));
    end
    hit = (state == SCAN) && (len_q != 4'd0) && reached &&
          (((hist_nxt ^ pat_q) & len_mask) == '0);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs; these fall straight to idle values when reset forces IDLE.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    serial_a      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = SCAN;
      end
      SCAN: begin
        busy     = 1'b1;
        serial_a = shreg[WIDTH-1];
        if (last_bit) state_nxt = REPORT;
      end
      REPORT: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Config latch, word capture, serial shift, history, bit counter and match counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q   <= PLEN_MAX'(1);
      len_q   <= 4'd2;
      shreg   <= '0;
      hist    <= '0;
      bitcnt  <= '0;
      count   <= '0;
      match_y <= 1'b0;
    end else begin
      match_y <= hit;
      if ((state == IDLE) && bus.cfg_we) begin
        pat_q <= bus.cfg_pattern;
        len_q <= len_clamp;
      end
      if (accept) begin
        shreg  <= bus.in_data;
        hist   <= '0;
        bitcnt <= '0;
        count  <= '0;
      end else if (state == SCAN) begin
        shreg  <= {shreg[WIDTH-2:0], 1'b0};
        hist   <= hist_nxt;
        bitcnt <= bitcnt + CW'(1);
        if (hit) count <= count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - scoreboard bench for seq_scan_ctrl against a sliding-window reference model
module tb_seq_scan_ctrl;
  localparam int WIDTH    = 16;
  localparam int PLEN_MAX = 8;
  localparam int CW       = $clog2(WIDTH + 1);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic serial_a;
  logic match_y;
  logic busy;

  seq_scan_ctrl_if #(.WIDTH(WIDTH), .PLEN_MAX(PLEN_MAX), .CW(CW)) sif ();

  seq_scan_ctrl #(.WIDTH(WIDTH), .PLEN_MAX(PLEN_MAX), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (sif.slave),
    .serial_a (serial_a),
    .match_y  (match_y),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cnt;
    logic [WIDTH-1:0] mask;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  m_pat;
  int          m_len;
  bit          rand_ready = 1'b0;
  int          idle_anom = 0;

  bit               mon_active = 1'b0;
  int               mon_c;
  int               mon_stray;
  int               first_valid;
  logic [CW-1:0]    held_count;
  logic [WIDTH-1:0] obs_ser;
  logic [WIDTH-1:0] obs_mt;
  exp_t             mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Bit t of the word in time is d[WIDTH-1-t]; a match ends at bit i when the last len bits equal the pattern.
  function automatic exp_t model(input logic [WIDTH-1:0] d, input logic [7:0] p, input int len);
    exp_t e;
    bit   ok;
    e.data = d;
    e.cnt  = 0;
    e.mask = '0;
    if (len > 0) begin
      for (int i = len - 1; i < WIDTH; i++) begin
        ok = 1'b1;
        for (int j = 0; j < len; j++) begin
          if (d[WIDTH-1-(i-len+1+j)] != p[len-1-j]) ok = 1'b0;
        end
        if (ok) begin
          e.cnt++;
          e.mask[WIDTH-1-i] = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) sif.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (sif.in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 32'(n < 200), 32'd1);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l);
    wait_ready();
    sif.cfg_we      = 1'b1;
    sif.cfg_pattern = p;
    sif.cfg_len     = l;
    m_pat = p;
    m_len = (l > 4'd8) ? 8 : int'(l);
    tick();
    sif.cfg_we = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d, input bit with_cfg,
                           input logic [7:0] p, input logic [3:0] l);
    wait_ready();
    if (with_cfg) begin
      sif.cfg_we      = 1'b1;
      sif.cfg_pattern = p;
      sif.cfg_len     = l;
      m_pat = p;
      m_len = (l > 4'd8) ? 8 : int'(l);
    end
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    sb.push_back(model(d, m_pat, m_len));
    tick();
    sif.in_valid = 1'b0;
    sif.cfg_we   = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() > 0 && n < 400) begin
      tick();
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: rebuilds the scanned word and match positions per word, then scores them at the result handshake.
  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else begin
      if (!busy && (serial_a !== 1'b0 || match_y !== 1'b0)) idle_anom++;
      if (!mon_active && busy) begin
        mon_active  = 1'b1;
        mon_c       = 0;
        mon_stray   = 0;
        first_valid = -1;
        obs_ser     = '0;
        obs_mt      = '0;
      end
      if (mon_active) begin
        if (mon_c < WIDTH) obs_ser[WIDTH-1-mon_c] = serial_a;
        if (match_y === 1'b1) begin
          if (mon_c >= 1 && mon_c <= WIDTH) obs_mt[WIDTH-mon_c] = 1'b1;
          else mon_stray++;
        end
        if (sif.out_valid === 1'b1) begin
          if (first_valid < 0) begin
            first_valid = mon_c;
            held_count  = sif.out_count;
          end else if (sif.out_count !== held_count) begin
            mon_stray++;
          end
        end
        if (sif.out_valid === 1'b1 && sif.out_ready === 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            mon_e = sb.pop_front();
            chk("out_count", 32'(sif.out_count), 32'(mon_e.cnt));
            chk("serial_word", 32'(obs_ser), 32'(mon_e.data));
            chk("match_positions", 32'(obs_mt), 32'(mon_e.mask));
            chk("result_latency", 32'(first_valid), 32'(WIDTH));
            chk("stray_or_unstable", 32'(mon_stray), 32'd0);
          end
          mon_active = 1'b0;
        end else begin
          mon_c++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   bp_cnt;
    logic [WIDTH-1:0] w;

    sif.cfg_we      = 1'b0;
    sif.cfg_pattern = '0;
    sif.cfg_len     = '0;
    sif.in_valid    = 1'b0;
    sif.in_data     = '0;
    sif.out_ready   = 1'b1;
    m_pat = 8'h01;
    m_len = 2;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(sif.in_ready), 32'd1);
    chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_serial_a", 32'(serial_a), 32'd0);
    chk("rst_match_y", 32'(match_y), 32'd0);
    chk("rst_out_count", 32'(sif.out_count), 32'd0);
    reset = 1'b0;
    tick();

    send_word(16'h5555, 1'b0, 8'h00, 4'd0);
    wait_done();

    cfg(8'h03, 4'd2);
    send_word(16'hFFFF, 1'b0, 8'h00, 4'd0);
    send_word(16'h0000, 1'b0, 8'h00, 4'd0);
    wait_done();

    cfg(8'hA5, 4'd8);
    send_word(16'hA5A5, 1'b0, 8'h00, 4'd0);
    cfg(8'hA5, 4'd12);
    send_word(16'hA5A5, 1'b0, 8'h00, 4'd0);
    wait_done();

    cfg(8'h01, 4'd2);
    sif.out_ready = 1'b0;
    bp_cnt = model(16'h5555, 8'h01, 2).cnt;
    send_word(16'h5555, 1'b0, 8'h00, 4'd0);
    n = 0;
    while (sif.out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("bp_valid_wait", 32'(n < 50), 32'd1);
    repeat (5) begin
      sif.in_valid = 1'b1;
      sif.in_data  = 16'($urandom);
      tick();
      chk("bp_out_valid", 32'(sif.out_valid), 32'd1);
      chk("bp_in_ready", 32'(sif.in_ready), 32'd0);
      chk("bp_out_count", 32'(sif.out_count), 32'(bp_cnt));
    end
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", 32'(sif.in_ready), 32'd1);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_release_drained", 32'(sb.size()), 32'd0);

    send_word(16'h5555, 1'b0, 8'h00, 4'd0);
    repeat (3) tick();
    sif.cfg_we      = 1'b1;
    sif.cfg_pattern = 8'h03;
    sif.cfg_len     = 4'd2;
    tick();
    sif.cfg_we = 1'b0;
    send_word(16'h5555, 1'b0, 8'h00, 4'd0);
    wait_done();

    cfg(8'h01, 4'd0);
    send_word(16'h5555, 1'b0, 8'h00, 4'd0);
    send_word(16'hFFFF, 1'b0, 8'h00, 4'd0);
    wait_done();

    send_word(16'h3333, 1'b1, 8'h03, 4'd2);
    wait_done();

    rand_ready = 1'b1;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) cfg(8'($urandom), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0)
        send_word(16'($urandom), 1'b1, 8'($urandom), 4'($urandom_range(1, 4)));
      else
        send_word(16'($urandom), 1'b0, 8'h00, 4'd0);
    end
    wait_done();
    rand_ready    = 1'b0;
    sif.out_ready = 1'b1;

    cfg(8'hA5, 4'd8);
    w = 16'($urandom);
    send_word(w, 1'b0, 8'h00, 4'd0);
    repeat (7) tick();
    reset = 1'b1;
    #1;
    chk("midrst_serial_a", 32'(serial_a), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_match_y", 32'(match_y), 32'd0);
    chk("midrst_out_valid", 32'(sif.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(sif.in_ready), 32'd1);
    void'(sb.pop_back());
    m_pat = 8'h01;
    m_len = 2;
    tick();
    reset = 1'b0;
    tick();
    send_word(16'h5555, 1'b0, 8'h00, 4'd0);
    wait_done();

    repeat (3) tick();
    chk("idle_anomalies", 32'(idle_anom), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Sequencer for the serial Moore pattern-detection datapath. It accepts a parallel word over a valid/ready handshake and feeds it one bit per cycle, MSB first, through a programmable serial pattern matcher. It pulses on every (overlapping) match, counts matches within the word, and returns the count over a second valid/ready handshake. It sits between a bus-side producer of sample words and any consumer of detection results, replacing hand-driven stimulus of the single-bit detector.

## Interface
- WIDTH, 16: bits per input word; scan length in cycles.
- PLEN_MAX, 8: maximum pattern length in bits.
- CW, $clog2(WIDTH+1): width of the match count.

- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; all registers to reset values immediately.
- cfg_we  in  1  pattern/length write strobe; honoured only in IDLE.
- cfg_pattern  in  PLEN_MAX  pattern bits; bit cfg_len-1 is the first bit in time, bit 0 the last.
- cfg_len  in  4  pattern length; 0 = match disabled; >PLEN_MAX clamped to PLEN_MAX.
- in_valid  in  1  input word valid.
- in_ready  out  1  high exactly when state is IDLE.
- in_data  in  WIDTH  word to scan.
- serial_a  out  1  bit currently being scanned (0 outside SCAN).
- match_y  out  1  registered one-cycle pulse per completed match.
- busy  out  1  high in SCAN and REPORT.
- out_valid  out  1  result valid (REPORT state).
- out_ready  in  1  consumer accepts result.
- out_count  out  CW  number of matches in the last word; held stable while out_valid.

## Operation
- States: IDLE, SCAN, REPORT. Reset state IDLE.
- Reset values: pattern = 8'b0000_0001, len = 2 (detects "01"); out_valid, match_y, serial_a, busy, out_count = 0; in_ready = 1. No handshake completes on an edge where reset is high.
- IDLE: in_ready=1. cfg_we=1 latches cfg_pattern and clamped cfg_len. in_valid&&in_ready: capture in_data into shift register; clear history, bit counter and match count; go to SCAN. If cfg_we and in_valid coincide, the new config applies to that word.
- SCAN: serial_a = shift register MSB. Each edge: shift left, history <= {history[PLEN_MAX-2:0], serial_a}, bitcnt++. Match when bitcnt+1 >= len, len != 0, and the low len bits of the new history equal the low len bits of the pattern. On match: count++, match_y=1 next cycle. Matches overlap and never span words (history cleared per word). After bit WIDTH-1, go to REPORT.
- REPORT: out_valid=1, out_count held. out_valid&&out_ready -> IDLE. in_valid and cfg_we are ignored.
- cfg_we outside IDLE is ignored with no side effects.
- Count cannot overflow: the maximum is WIDTH-len+1 <= WIDTH.

## Timing
- Input accepted at edge k. Bit i (0 = MSB) is on serial_a in cycle k+1+i, i = 0..WIDTH-1.
- match_y for a match ending on bit i is high in cycle k+2+i only. The last bit's pulse coincides with the first out_valid cycle.
- out_valid is first high in cycle k+WIDTH+1 (latency WIDTH+1 from acceptance) and already includes the last bit's match.
- Output handshake at edge m: in_ready=1 in cycle m+1, so the next word is accepted no earlier than edge m+1. Throughput is one word per WIDTH+2 cycles minimum.
- out_ready may be held high continuously. REPORT then lasts exactly one cycle.
- Reset mid-SCAN or mid-REPORT: outputs drop combinationally with reset. The word in flight and its count are discarded. Configuration returns to the defaults.

## Test plan
- Reset defaults, in_data=16'h5555 -> serial_a = 0,1,0,1,…; 8 match_y pulses (after bits 1,3,…,15); out_count=8 in cycle k+17.
- cfg_pattern=8'b11, cfg_len=2, in_data=16'hFFFF -> 15 overlapping pulses, out_count=15; in_data=16'h0000 -> out_count=0, no pulses.
- cfg_pattern=8'hA5, cfg_len=8, in_data=16'hA5A5 -> pulses after bits 7 and 15 only; out_count=2. cfg_len=12 with the same pattern -> clamped to 8, same result.
- Backpressure: hold out_ready=0 for 5 cycles in REPORT -> out_valid=1, out_count stable, in_ready=0; a concurrent in_valid is not accepted. out_ready=1 -> IDLE the next cycle.
- cfg_we with pattern 8'b11 during SCAN -> ignored; the current and next word still use the prior pattern. cfg_len=0 -> out_count=0, match_y never pulses.
- Assert reset at bit 7 of a SCAN -> serial_a, busy, match_y, out_valid = 0 immediately, in_ready=1. Then in_data=16'h5555 -> out_count=8 with the default "01" pattern.
